// File: rtl/mul16_seq_dp.sv
// Shift-add multiplier datapath (16x16 -> 32, unsigned) driven by an external
// 4-bit iteration controller through init / ld / fin strobes. One iteration per
// ld edge; the product is captured on fin and flagged with a one-cycle vld.
module mul16_seq_dp (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        i_init,
  input  logic        i_ld,
  input  logic        i_fin,
  input  logic [15:0] i_x,
  input  logic [15:0] i_y,
  output logic [3:0]  o_itr,
  output logic [31:0] o_prod,
  output logic        o_vld,
  output logic        o_err
);

  logic [15:0] r_m;      // multiplicand
  logic [16:0] r_a;      // partial sum plus carry
  logic [15:0] r_q;      // multiplier, shifts out as low product bits arrive
  logic [3:0]  r_cnt;    // iteration index
  logic        r_armed;  // iterations still outstanding for the current job
  logic        r_done;   // a job has completed since the last init
  logic [31:0] r_prod;
  logic        r_vld;
  logic        r_err;

  logic [16:0] w_sum;

  // Conditional add of the multiplicand; A[16] is always zero after a shift,
  // so adding the full 17-bit A is the same as adding {1'b0, A[15:0]}.
  always_comb begin
    w_sum = r_a + (r_q[0] ? {1'b0, r_m} : 17'd0);
  end

  // Operand load, iteration, product capture and protocol checking.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_m     <= '0;
      r_a     <= '0;
      r_q     <= '0;
      r_cnt   <= '0;
      r_armed <= 1'b0;
      r_done  <= 1'b0;
      r_prod  <= '0;
      r_vld   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments mean every rule below reads the pre-edge
      // state, so a fin arriving with ld judges the capture on the old armed.
      r_vld <= 1'b0;
      if (i_init) begin
        r_m     <= i_x;
        r_q     <= i_y;
        r_a     <= '0;
        r_cnt   <= '0;
        r_armed <= 1'b1;
        r_done  <= 1'b0;
        r_err   <= 1'b0;
      end else begin
        if (i_ld) begin
          if (r_armed) begin
            {r_a, r_q} <= {1'b0, w_sum, r_q[15:1]};
            r_cnt      <= r_cnt + 4'd1;
            if (r_cnt == 4'd15) begin
              r_armed <= 1'b0;
              r_done  <= 1'b1;
            end
          end else begin
            r_err <= 1'b1;
          end
        end
        if (i_fin) begin
          if (!r_armed && r_done) begin
            r_prod <= {r_a[15:0], r_q};
            r_vld  <= 1'b1;
          end else begin
            r_err <= 1'b1;
          end
        end
      end
    end
  end

  assign o_itr  = r_cnt;
  assign o_prod = r_prod;
  assign o_vld  = r_vld;
  assign o_err  = r_err;

endmodule

// File: doc/mul16_seq_dp.md
# mul16_seq_dp

Datapath partner of the 4-bit iteration controller. It consumes the controller's `init`, `ld` and `fin` strobes, performs a 16-step shift-add unsigned multiplication of two 16-bit operands, and returns the iteration count `itr` that the controller compares against 15 to leave its loop. It sits directly below the controller. The result is registered on `fin` and presented with a one-cycle valid pulse.

## Interface
- No parameters. Width is fixed at 16×16→32, with 16 iterations matching the 4-bit `itr`.
- `clk`  in  1  clock, rising edge.
- `rst_b`  in  1  reset, asynchronous, active-low.
- `init`  in  1  from controller; load operands and clear the iteration state.
- `ld`  in  1  from controller; perform one iteration (ignored for iteration when `init`=1).
- `fin`  in  1  from controller; capture the product.
- `x`  in  16  multiplicand, sampled only on an `init` edge.
- `y`  in  16  multiplier, sampled only on an `init` edge.
- `itr`  out  4  current iteration index, back to the controller.
- `prod`  out  32  registered product, held until the next valid capture.
- `vld`  out  1  one-cycle pulse after a valid capture.
- `err`  out  1  sticky protocol-violation flag; cleared by reset or by `init`.

## Operation
- Internal registers:
  - M[15:0], multiplicand.
  - A[16:0], partial sum plus carry.
  - Q[15:0], multiplier / low product.
  - cnt[3:0], drives `itr`.
  - armed, 1 bit.
- Reset (async): M, A, Q, cnt, armed, `prod`, `vld` and `err` all go to 0. Reset mid-operation abandons the job; no capture follows.
- `init`=1 has top priority, regardless of `ld` and `fin`:
  - M←x, Q←y, A←0, cnt←0, armed←1, err←0.
- `ld`=1, `init`=0, armed=1 (one iteration):
  - If Q[0]=1, S = {1'b0, A[15:0]} + {1'b0, M} (17-bit sum); otherwise S = {1'b0, A[15:0]}.
  - {A,Q} ← {1'b0, S, Q[15:1]}, i.e. a 33-bit logical right shift of {S,Q}.
  - cnt←cnt+1, wrapping 15→0.
  - If cnt was 15, armed←0.
- `ld`=1, `init`=0, armed=0: no datapath change; err←1.
- `fin`=1, `init`=0:
  - If armed=0 and at least one job has completed since the last `init`: prod←{A[15:0],Q}, vld←1 next cycle.
  - Otherwise err←1; `prod` is unchanged and there is no `vld`.
- `fin` together with `ld`: the `ld` rules apply first. The capture then uses the pre-edge armed value; if armed was 1, this is an error.
- Repeated `fin` after a valid capture re-captures the same value and pulses `vld` again. This is legal.
- `vld` defaults to 0 on every other edge.
- A[16] is always 0 after the shift; no overflow is possible, since 16×16 fits in 32 bits.

## Timing
- Controller sequence:
  - Edge E0: bgn cycle, `ld`=`init`=1 → load; cnt=0.
  - Edges E1..E16: S1 cycles with `ld`=1, `itr`=0..15 → 16 iterations.
  - At `itr`=15 the controller moves to S2. After E16, cnt=0 and armed=0.
  - Edge E17: `fin`=1 → `prod` captured.
  - `vld`=1 during the cycle following E17.
- Latency: 18 rising edges from the `init` edge to `prod` update, inclusive.
- `itr` is a pure register output with no combinational path from the inputs. It is stable for the controller's comparison in the same cycle.
- `prod` changes only on a valid `fin` edge (or on reset).
- `init` during an active job restarts it immediately with the new `x`/`y`, and the old job is discarded.

## Test plan
- Basic: x=3, y=5 through a full controller sequence → `itr` steps 0..15, `prod`=0x0000000F, `vld` is high for exactly 1 cycle after E17.
- Max: x=0xFFFF, y=0xFFFF → `prod`=0xFFFE0001. Check that the carry into A[16] is handled on every iteration.
- Zero / identity: x=0, y=0xABCD → `prod`=0. Then x=0x1234, y=1 → `prod`=0x00001234. Run back-to-back with `init` in the cycle right after `fin`; each `vld` must carry the correct product.
- Protocol: `ld` with no prior `init` → `err`=1 and registers unchanged. `fin` while armed (after 8 iterations) → `err`=1, `prod` unchanged, no `vld`. A following `init` clears `err`.
- Restart: `init` at `itr`=7 with x=2, y=9 → `itr`=0, and after 16 `ld` cycles plus `fin`, `prod`=18.
- Reset: assert `rst_b`=0 asynchronously mid-iteration (`itr`=5) → all outputs 0 immediately. A later `fin` without `init` → `err`=1, `prod` stays 0.
